// File: rtl/seq_detect_fsm.sv
// Serial bit-pattern detector: pulses flag for one clock when the last LEN
// samples of din equal PATTERN (first-received bit is PATTERN[LEN-1]).
module seq_detect_fsm #(
    parameter int             LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b10110,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flag
);

    // The default overlapping 10110 detector maps onto a six-state Moore
    // machine; every other configuration uses the shift-history datapath.
    localparam bit USE_FSM = (LEN == 5) && (PATTERN == LEN'(22)) && OVERLAP;

    if (USE_FSM) begin : g_fsm
        typedef enum logic [2:0] {
            IDLE, S1, S10, S101, S1011, S10110
        } state_e;

        state_e state_q, state_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) state_q <= IDLE;
            else     state_q <= state_d;
        end

        always_comb begin
            state_d = IDLE;
            case (state_q)
                IDLE:    state_d = din ? S1    : IDLE;
                S1:      state_d = din ? S1    : S10;
                S10:     state_d = din ? S101  : IDLE;
                S101:    state_d = din ? S1011 : S10;
                S1011:   state_d = din ? S1    : S10110;
                // Trailing "10" of a match is reused as the next prefix.
                S10110:  state_d = din ? S101  : IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Decoded straight from the state register, so no path from din.
        assign flag = (state_q == S10110);
    end else begin : g_shift
        localparam int CW = $clog2(LEN + 1);

        logic [LEN-1:0] hist_q, hist_d;
        logic [CW-1:0]  cnt_q, cnt_d;
        logic           flag_q, flag_d;
        logic [CW-1:0]  ncnt;

        always_comb begin
            hist_d = {hist_q[LEN-2:0], din};
            ncnt   = (cnt_q == CW'(LEN)) ? cnt_q : cnt_q + CW'(1);
            // Count gate first so a zero-filled history never matches.
            flag_d = (ncnt == CW'(LEN)) && (hist_d == PATTERN);
            cnt_d  = (flag_d && !OVERLAP) ? '0 : ncnt;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist_q <= '0;
                cnt_q  <= '0;
                flag_q <= 1'b0;
            end else begin
                hist_q <= hist_d;
                cnt_q  <= cnt_d;
                flag_q <= flag_d;
            end
        end

        assign flag = flag_q;
    end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: default overlapping 10110 detector,
// non-overlapping 10110 detector, and an overlapping LEN=3 "111" detector.
module tb_seq_detect_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic flag_a, flag_b, flag_c;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    seq_detect_fsm u_ov1 (.clk(clk), .rst(rst), .din(din), .flag(flag_a));

    seq_detect_fsm #(.LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b0))
        u_ov0 (.clk(clk), .rst(rst), .din(din), .flag(flag_b));

    seq_detect_fsm #(.LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1))
        u_l3 (.clk(clk), .rst(rst), .din(din), .flag(flag_c));

    task automatic chk(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ea, input logic eb, input logic ec);
        chk({tag, "/ov1"}, flag_a, ea);
        chk({tag, "/ov0"}, flag_b, eb);
        chk({tag, "/len3"}, flag_c, ec);
    endtask

    // Drive a bit at the falling edge, sample flags 1 ns after the rising edge.
    task automatic tick(input logic b);
        @(negedge clk);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sample k (1-based) uses bit [n-k] of each vector.
    task automatic run_seq(input string tag, input int n, input logic [31:0] bits,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] ec);
        for (int i = 0; i < n; i++) begin
            tick(bits[n-1-i]);
            chk_all($sformatf("%s_s%0d", tag, i + 1), ea[n-1-i], eb[n-1-i], ec[n-1-i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: long stream, hits at samples 5 and 10 for both 10110 detectors
        do_reset("t1");
        run_seq("t1", 17, 32'b10110101101111011,
                32'b00001000010000000, 32'b00001000010000000,
                32'b00000000000011000);

        // 2: overlap reuses the trailing "10"; non-overlap does not
        do_reset("t2");
        run_seq("t2", 8, 32'b10110110, 32'b00001001, 32'b00001000, 32'b0);

        // 3: async reset mid-pattern, earlier bits must not count
        do_reset("t3");
        run_seq("t3a", 4, 32'b1011, 32'b0, 32'b0, 32'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("t3_async", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("t3_held", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("t3b", 6, 32'b010110, 32'b000001, 32'b000001, 32'b0);

        // 4: constant streams
        do_reset("t4z");
        run_seq("t4z", 20, 32'b0, 32'b0, 32'b0, 32'b0);
        do_reset("t4o");
        run_seq("t4o", 20, 32'hFFFFF, 32'b0, 32'b0, 32'b00111111111111111111);

        // 5: reset while flag is high drops it before the next edge
        do_reset("t5");
        run_seq("t5", 5, 32'b10110, 32'b00001, 32'b00001, 32'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("t5_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 6: LEN=3 "111" with overlap fires on every sample from the third
        do_reset("t6");
        run_seq("t6", 5, 32'b11111, 32'b0, 32'b0, 32'b00111);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
